mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit for the Mini-MIPS execute stage, implementing MULT, MULTU, DIV and DIVU.
- Results are written to the HI/LO pair.
- All additions, subtractions and sign negations go through one instance of the existing adder_32bit; the unit sequences that adder over 32+ cycles.
- The pipeline controller issues `start` and stalls on `busy`.

---
 rtl/mips_pkg.sv | 19 +
 rtl/adder_32bit.sv | 15 +
 rtl/mdu_iterative.sv | 158 +++++++++++++++
 tb/tb_mdu_iterative.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared Mini-MIPS definitions: multiply/divide opcodes, MDU state encoding and iteration count.
package mips_pkg;

    localparam logic [1:0] MDU_OP_MULT  = 2'd0;
    localparam logic [1:0] MDU_OP_MULTU = 2'd1;
    localparam logic [1:0] MDU_OP_DIV   = 2'd2;
    localparam logic [1:0] MDU_OP_DIVU  = 2'd3;

    localparam int MDU_ITER = 32;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX_LO,
        FIX_HI,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit two-operand adder with carry-in, carry-out and signed overflow.
// Purely combinational; no flow control.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    assign overflow    = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/mdu_iterative.sv
// Shift-add multiplier / restoring divider for MULT(U)/DIV(U) writing HI/LO, built around one adder.
// 35 cycles from accept to done (1 on divide-by-zero); start ignored while busy or done.
module mdu_iterative
    import mips_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    if (WIDTH != 32) begin : g_width_chk
        $error("mdu_iterative: WIDTH must be 32 to match adder_32bit");
    end

    localparam logic [4:0] ITER_LAST = 5'(MDU_ITER - 1);

    mdu_state_t       state;
    logic             is_div, sign_q, sign_r, b_neg, fix_c, dbz_pend;
    logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
    logic [4:0]       count;

    logic             signed_op, dbz, accept;
    logic [WIDTH-1:0] add_a, add_b, add_sum, rem_sh, mul_hi;
    logic             add_cin, add_cout, add_unused_ovf, mul_c, div_take;

    assign signed_op = ~op[0];
    assign dbz       = op[1] && (b == '0);
    assign accept    = (state == IDLE) && start && !done;
    assign rem_sh    = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    assign mul_hi    = acc_lo[0] ? add_sum : acc_hi;
    assign mul_c     = acc_lo[0] & add_cout;
    assign div_take  = acc_hi[WIDTH-1] | add_cout;

    // Only |a| is stored; a negative b is kept raw because rem - |b| == rem + b and
    // acc + |b| == acc + ~b + 1 produce the same 33-bit sum, so one negation suffices.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            IDLE: begin
                add_a   = ~a;
                add_cin = 1'b1;
            end
            CALC: begin
                if (is_div) begin
                    add_a   = rem_sh;
                    add_b   = b_neg ? mcand : ~mcand;
                    add_cin = ~b_neg;
                end else begin
                    add_a   = acc_hi;
                    add_b   = b_neg ? ~mcand : mcand;
                    add_cin = b_neg;
                end
            end
            FIX_LO: begin
                add_a   = ~acc_lo;
                add_cin = 1'b1;
            end
            FIX_HI: begin
                add_a   = ~acc_hi;
                add_cin = is_div ? 1'b1 : fix_c;
            end
            default: ;
        endcase
    end

    adder_32bit u_adder (
        .a        (add_a),
        .b        (add_b),
        .cin      (add_cin),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_unused_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div      <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            b_neg       <= 1'b0;
            fix_c       <= 1'b0;
            dbz_pend    <= 1'b0;
            mcand       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            count       <= '0;
        end else begin
            done <= (state == DONE);
            busy <= (state == CALC) || (state == FIX_LO) || (state == FIX_HI);
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div      <= op[1];
                        sign_q      <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r      <= signed_op & a[WIDTH-1];
                        b_neg       <= signed_op & b[WIDTH-1];
                        mcand       <= b;
                        acc_hi      <= '0;
                        acc_lo      <= (signed_op && a[WIDTH-1] && !dbz) ? add_sum : a;
                        count       <= ITER_LAST;
                        div_by_zero <= 1'b0;
                        dbz_pend    <= dbz;
                        state       <= dbz ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_take ? add_sum : rem_sh;
                        acc_lo <= {acc_lo[WIDTH-2:0], div_take};
                    end else begin
                        acc_hi <= {mul_c, mul_hi[WIDTH-1:1]};
                        acc_lo <= {mul_hi[0], acc_lo[WIDTH-1:1]};
                    end
                    if (count == '0) state <= FIX_LO;
                    else             count <= count - 5'd1;
                end
                FIX_LO: begin
                    lo    <= sign_q ? add_sum : acc_lo;
                    fix_c <= add_cout;
                    state <= FIX_HI;
                end
                FIX_HI: begin
                    hi    <= (is_div ? sign_r : sign_q) ? add_sum : acc_hi;
                    state <= DONE;
                end
                DONE: begin
                    if (dbz_pend) begin
                        lo          <= DIVZERO_LO;
                        hi          <= acc_lo;
                        div_by_zero <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: reference results from native 64-bit arithmetic.
module tb_mdu_iterative;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, div_by_zero;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;

    mdu_iterative dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MDU_OP_MULT: begin
                p    = 64'(sx * sy);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_OP_MULTU: begin
                p    = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    e.hi  = x;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == MDU_OP_DIV) begin
                    q    = sx / sy;
                    r    = sx % sy;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle following the accept edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input bit push, output int n_acc);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        n_acc = cyc + 1;
        if (push) sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input int n_acc, output int lat, output int nb);
        nb  = 0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                lat = cyc - n_acc;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        if (lat < 0) check("done_timeout", 64'(lat), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int n, lat, nb;
        start_op(o, x, y, 1'b1, n);
        wait_done(n, lat, nb);
        check("latency", 64'(lat), (o[1] && y == 32'd0) ? 64'd1 : 64'd35);
        @(negedge clk);
    endtask

    initial begin
        int   n, lat, nb;
        exp_t prev;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, n);
        wait_done(n, lat, nb);
        check("mult_latency", 64'(lat), 64'd35);
        check("mult_busy_cycles", 64'(nb), 64'd34);
        check("busy_in_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MDU_OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(MDU_OP_DIVU,  32'd100,       32'd7);
        run_op(MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MDU_OP_DIVU,  32'h0000_1234, 32'd0);

        // Back-to-back after the divide-by-zero: old hi/lo must hold until the FIX writes.
        prev = model(MDU_OP_DIVU, 32'h0000_1234, 32'd0);
        start_op(MDU_OP_MULT, 32'd6, 32'hFFFF_FFF9, 1'b1, n);
        check("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
        check("busy_after_accept", 64'(busy), 64'd0);
        while (cyc < n + 20) @(negedge clk);
        check("hold_hi", 64'(hi), 64'(prev.hi));
        check("hold_lo", 64'(lo), 64'(prev.lo));
        check("busy_mid_op", 64'(busy), 64'd1);
        wait_done(n, lat, nb);
        check("b2b_latency", 64'(lat), 64'd35);
        @(negedge clk);

        // A second start mid-operation must be ignored; only the first result is expected.
        start_op(MDU_OP_MULT, 32'd12345, 32'hFFFF_FD5A, 1'b1, n);
        repeat (9) @(negedge clk);
        begin
            int dummy;
            start_op(MDU_OP_DIVU, 32'd999, 32'd3, 1'b0, dummy);
        end
        wait_done(n, lat, nb);
        check("repulse_latency", 64'(lat), 64'd35);
        @(negedge clk);

        // Synchronous reset in the middle of a divide.
        start_op(MDU_OP_DIV, 32'h7654_3210, 32'hFFFF_FF85, 1'b1, n);
        while (cyc < n + 20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        run_op(MDU_OP_DIVU, 32'hDEAD_BEEF, 32'd1000);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx, ry;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 5000)));
            if (i == 5) ry = 32'h8000_0000;
            run_op(ro, rx, ry);
        end

        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
